// File: rtl/alarm_event_gen.sv
// Alarm event generator: debounced keys plus an IDLE/RING/SNOOZE/DONE ring sequencer.
// Latency: key edge to df/df_0 is DB_CYCLES+2 clk_in; time match to ed low is 2 clk_in.
// Backpressure: none; presses and ticks are one-cycle events consumed when they occur.
module alarm_event_gen #(
    parameter int DB_CYCLES  = 20,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       tick_1s,
    input  logic       key_set_n,
    input  logic       key_stop_n,
    input  logic       alm_en,
    input  logic [4:0] cur_hh,
    input  logic [4:0] alm_hh,
    input  logic [5:0] cur_mm,
    input  logic [5:0] alm_mm,
    output logic       df,
    output logic       df_0,
    output logic       ed,
    output logic [1:0] alm_state
);

    localparam int DW = (DB_CYCLES  > 1) ? $clog2(DB_CYCLES)  : 1;
    localparam int RW = (RING_SEC   > 1) ? $clog2(RING_SEC)   : 1;
    localparam int SW = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC) : 1;
    localparam logic [DW-1:0] DB_MAX   = DW'(DB_CYCLES - 1);
    localparam logic [RW-1:0] RING_MAX = RW'(RING_SEC - 1);
    localparam logic [SW-1:0] SNZ_MAX  = SW'(SNOOZE_SEC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RING   = 2'b01,
        SNOOZE = 2'b10,
        DONE   = 2'b11
    } state_t;

    // Bit 0 = set key, bit 1 = stop key. The inversion is folded ahead of the
    // synchronizer so a cleared flop means "released".
    logic [1:0]    sync1, sync2, db, db_d;
    logic [DW-1:0] db_cnt [2];

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
            db    <= 2'b00;
            db_d  <= 2'b00;
            for (int k = 0; k < 2; k++) db_cnt[k] <= '0;
        end else begin
            sync1 <= ~{key_stop_n, key_set_n};
            sync2 <= sync1;
            db_d  <= db;
            for (int k = 0; k < 2; k++) begin
                if (sync2[k] == db[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == DB_MAX) begin
                    db[k]     <= sync2[k];
                    db_cnt[k] <= '0;
                end else begin
                    db_cnt[k] <= db_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign df   = db[0];
    assign df_0 = db[1];

    logic set_press, stop_press, tick_ok;
    assign set_press  = db[0] & ~db_d[0];
    assign stop_press = db[1] & ~db_d[1];
    assign tick_ok    = tick_1s & ~set_press & ~stop_press;

    // armed stays low out of reset until the compare has been seen false, so a
    // match already true at release cannot ring until it falls and rises.
    logic match_now, match_r, match_d, armed, match_rise;
    assign match_now  = (cur_hh == alm_hh) && (cur_mm == alm_mm);
    assign match_rise = match_r & ~match_d;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            match_r <= 1'b0;
            match_d <= 1'b0;
            armed   <= 1'b0;
        end else begin
            match_r <= match_now;
            match_d <= match_r;
            armed   <= armed | ~match_now;
        end
    end

    state_t        state;
    logic [RW-1:0] ring_cnt;
    logic [SW-1:0] snz_cnt;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ed       <= 1'b1;
            ring_cnt <= '0;
            snz_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (alm_en && match_rise && armed) begin
                        state    <= RING;
                        ed       <= 1'b0;
                        ring_cnt <= '0;
                    end
                end
                RING: begin
                    if (!alm_en) begin
                        state <= IDLE;
                        ed    <= 1'b1;
                    end else if (stop_press) begin
                        state <= DONE;
                        ed    <= 1'b1;
                    end else if (set_press) begin
                        state   <= SNOOZE;
                        ed      <= 1'b1;
                        snz_cnt <= '0;
                    end else if (tick_ok) begin
                        if (ring_cnt == RING_MAX) begin
                            state <= DONE;
                            ed    <= 1'b1;
                        end else begin
                            ring_cnt <= ring_cnt + 1'b1;
                        end
                    end
                end
                SNOOZE: begin
                    if (!alm_en) begin
                        state <= IDLE;
                    end else if (stop_press) begin
                        state <= DONE;
                    end else if (tick_ok) begin
                        if (snz_cnt == SNZ_MAX) begin
                            state    <= RING;
                            ed       <= 1'b0;
                            ring_cnt <= '0;
                        end else begin
                            snz_cnt <= snz_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!alm_en || !match_r) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    ed    <= 1'b1;
                end
            endcase
        end
    end

    assign alm_state = state;

endmodule

// File: tb/tb_alarm_event_gen.sv
// Directed bench for alarm_event_gen with DB_CYCLES=4, RING_SEC=5, SNOOZE_SEC=3.
module tb_alarm_event_gen;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       tick_1s;
    logic       key_set_n, key_stop_n;
    logic       alm_en;
    logic [4:0] cur_hh, alm_hh;
    logic [5:0] cur_mm, alm_mm;
    logic       df, df_0, ed;
    logic [1:0] alm_state;

    int checks = 0;
    int errors = 0;

    alarm_event_gen #(.DB_CYCLES(4), .RING_SEC(5), .SNOOZE_SEC(3)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .tick_1s    (tick_1s),
        .key_set_n  (key_set_n),
        .key_stop_n (key_stop_n),
        .alm_en     (alm_en),
        .cur_hh     (cur_hh),
        .alm_hh     (alm_hh),
        .cur_mm     (cur_mm),
        .alm_mm     (alm_mm),
        .df         (df),
        .df_0       (df_0),
        .ed         (ed),
        .alm_state  (alm_state)
    );

    always #5 clk_in = ~clk_in;

    localparam logic [1:0] S_IDLE = 2'b00, S_RING = 2'b01, S_SNZ = 2'b10, S_DONE = 2'b11;

    typedef struct {
        logic       tick;
        logic       en;
        logic [5:0] cmm;
        logic [1:0] exp_state;
        logic       exp_ed;
    } vec_t;

    vec_t vecs [16];

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    task automatic chk_fsm(input string name, input logic [1:0] st, input logic e);
        check({name, "_state"}, {6'd0, alm_state}, {6'd0, st});
        check({name, "_ed"}, {7'd0, ed}, {7'd0, e});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Ring-on-match then timeout; cur fixed at hour 7, alarm 07:30.
        vecs[0]  = '{1'b0, 1'b1, 6'd29, S_IDLE, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 6'd30, S_IDLE, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 6'd30, S_RING, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 6'd30, S_RING, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 6'd30, S_RING, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 6'd30, S_RING, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 6'd30, S_RING, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 6'd30, S_RING, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 6'd30, S_RING, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 6'd30, S_DONE, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 6'd30, S_DONE, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 6'd31, S_DONE, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 6'd31, S_IDLE, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 6'd30, S_IDLE, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 6'd30, S_IDLE, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 6'd30, S_IDLE, 1'b1};

        rst = 1'b1; tick_1s = 1'b0; key_set_n = 1'b1; key_stop_n = 1'b1;
        alm_en = 1'b0; cur_hh = 5'd0; cur_mm = 6'd0; alm_hh = 5'd0; alm_mm = 6'd0;
        step(3);
        check("rst_df", {7'd0, df}, 8'd0);
        check("rst_df0", {7'd0, df_0}, 8'd0);
        chk_fsm("rst", S_IDLE, 1'b1);

        rst = 1'b0; cur_hh = 5'd7; alm_hh = 5'd7; alm_mm = 6'd30;
        for (int v = 0; v < 16; v++) begin
            tick_1s = vecs[v].tick;
            alm_en  = vecs[v].en;
            cur_mm  = vecs[v].cmm;
            step(1);
            chk_fsm($sformatf("vec%0d", v), vecs[v].exp_state, vecs[v].exp_ed);
        end
        tick_1s = 1'b0;

        // Debounce: two 2-cycle glitches are rejected, stable low lands after 6 edges.
        cur_mm = 6'd0;
        for (int g = 0; g < 2; g++) begin
            key_set_n = 1'b0;
            step(2);
            key_set_n = 1'b1;
            for (int i = 0; i < 3; i++) begin
                step(1);
                check($sformatf("glitch%0d_df", g), {7'd0, df}, 8'd0);
            end
        end
        step(4);
        key_set_n = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            check($sformatf("db_hold%0d_df", i), {7'd0, df}, (i >= 6) ? 8'd1 : 8'd0);
        end
        key_set_n = 1'b1;
        step(8);
        check("db_release_df", {7'd0, df}, 8'd0);
        chk_fsm("db_idle", S_IDLE, 1'b1);

        // Ring, snooze, re-ring after 3 ticks despite alarm time edit, then stop.
        cur_mm = 6'd30;
        step(2);
        chk_fsm("ring2", S_RING, 1'b0);
        key_set_n = 1'b0;
        step(7);
        chk_fsm("snooze", S_SNZ, 1'b1);
        key_set_n = 1'b1;
        step(8);
        alm_mm = 6'd45;
        step(1);
        for (int t = 0; t < 3; t++) begin
            tick_1s = 1'b1;
            step(1);
            tick_1s = 1'b0;
            step(1);
            if (t < 2) chk_fsm($sformatf("snz_tick%0d", t), S_SNZ, 1'b1);
            else       chk_fsm("rering", S_RING, 1'b0);
        end
        key_stop_n = 1'b0;
        step(7);
        chk_fsm("stop_done", S_DONE, 1'b1);
        key_stop_n = 1'b1;
        step(8);
        chk_fsm("stop_idle", S_IDLE, 1'b1);

        // Simultaneous set+stop in RING: stop wins.
        alm_mm = 6'd30;
        step(2);
        chk_fsm("ring3", S_RING, 1'b0);
        key_set_n = 1'b0; key_stop_n = 1'b0;
        step(7);
        chk_fsm("both_done", S_DONE, 1'b1);
        key_set_n = 1'b1; key_stop_n = 1'b1;
        step(8);
        chk_fsm("done_hold", S_DONE, 1'b1);
        cur_mm = 6'd31;
        step(2);
        chk_fsm("done_exit", S_IDLE, 1'b1);

        // alm_en drop coincident with stop_press: IDLE wins.
        cur_mm = 6'd30;
        step(2);
        chk_fsm("ring4", S_RING, 1'b0);
        key_stop_n = 1'b0;
        step(6);
        alm_en = 1'b0;
        step(1);
        chk_fsm("en_drop", S_IDLE, 1'b1);
        key_stop_n = 1'b1;
        step(8);
        alm_en = 1'b1;
        step(3);
        chk_fsm("no_retrigger", S_IDLE, 1'b1);

        // Reset mid-RING aborts at once; held match must toggle before ringing again.
        cur_mm = 6'd31;
        step(2);
        cur_mm = 6'd30;
        step(2);
        chk_fsm("ring5", S_RING, 1'b0);
        rst = 1'b1;
        #1;
        chk_fsm("async_rst", S_IDLE, 1'b1);
        step(2);
        rst = 1'b0;
        step(5);
        chk_fsm("post_rst", S_IDLE, 1'b1);
        cur_mm = 6'd31;
        step(2);
        cur_mm = 6'd30;
        step(2);
        chk_fsm("ring6", S_RING, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_event_gen.md
ALARM_EVENT_GEN -- requirements
Module: alarm_event_gen

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 20: consecutive clk_in cycles a synced key level must hold before its debounced output changes.
REQ-002 SHALL have parameter RING_SEC, default 60: tick_1s count after which an unanswered ring ends.
REQ-003 SHALL have parameter SNOOZE_SEC, default 300: tick_1s count spent in snooze before ringing again.
REQ-004 SHALL use one clock and an asynchronous, active-high reset (clk_in, rst), stated exactly so; there is no other clock.
REQ-005 clk_in  input  1  system clock; all flops on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 tick_1s  input  1  one-clk_in-cycle strobe, once per second.
REQ-008 key_set_n  input  1  raw set/snooze button, active-low, asynchronous to clk_in.
REQ-009 key_stop_n  input  1  raw stop button, active-low, asynchronous to clk_in.
REQ-010 alm_en  input  1  alarm enable.
REQ-011 cur_hh, alm_hh  input  5 each  current and alarm hour, 0-23.
REQ-012 cur_mm, alm_mm  input  6 each  current and alarm minute, 0-59.
REQ-013 df  output  1  debounced set key, 1 = pressed.
REQ-014 df_0  output  1  debounced stop key, 1 = pressed.
REQ-015 ed  output  1  alarm request, active-low (0 = ringing).
REQ-016 alm_state  output  2  current FSM state encoding.

Function
REQ-017 Each key SHALL pass through a 2-flop synchronizer, then be inverted to active-high.
REQ-018 Debounce: a per-key counter SHALL clear whenever the synced level equals the debounced output; otherwise it SHALL increment, and on reaching DB_CYCLES-1 the output SHALL take the synced level and the counter SHALL clear. Latency from raw edge to df/df_0 change is DB_CYCLES+2 cycles.
REQ-019 set_press and stop_press SHALL be internal one-cycle pulses on the 0->1 transitions of df and df_0.
REQ-020 match SHALL be (cur_hh==alm_hh && cur_mm==alm_mm), registered once; match_rise SHALL be match & ~match_d.
REQ-021 FSM states: IDLE=00, RING=01, SNOOZE=10, DONE=11.
REQ-022 IDLE: alm_en && match_rise -> RING; ring counter cleared.
REQ-023 RING: ed=0; ring counter SHALL increment on each tick_1s; exit to DONE on stop_press, to SNOOZE (snooze counter cleared) on set_press, to DONE on tick_1s when the counter equals RING_SEC-1.
REQ-024 SNOOZE: ed=1; snooze counter SHALL increment on tick_1s; on tick_1s with counter equal to SNOOZE_SEC-1 -> RING (ring counter cleared); stop_press -> DONE.
REQ-025 DONE: ed=1; -> IDLE when match==0.
REQ-026 Priority on simultaneous events in any state: alm_en==0 (-> IDLE) > stop_press > set_press > timeout.
REQ-027 ed SHALL be a registered output, 0 exactly while state==RING.
REQ-028 Counters SHALL be sized to hold RING_SEC-1 and SNOOZE_SEC-1 and SHALL never wrap; a tick_1s arriving in the same cycle as a press SHALL be ignored for counting.
REQ-029 A match that persists after a RING/SNOOZE cycle SHALL NOT retrigger; a new ring requires match to fall and rise again.
REQ-030 Changing alm_hh/alm_mm while in SNOOZE SHALL NOT affect the pending re-ring.

Reset
REQ-031 While rst=1: df=0, df_0=0, ed=1, alm_state=IDLE, all counters and synchronizers cleared, match_d=0.
REQ-032 Reset asserted mid-RING or mid-SNOOZE SHALL abort immediately (ed=1 asynchronously); after release a still-true match SHALL NOT ring until it falls and rises.

Verification (DB_CYCLES=4, RING_SEC=5, SNOOZE_SEC=3)
REQ-033 key_set_n low with 2-cycle glitches, then held low 10 cycles -> df stays 0 on glitches, rises 6 cycles after stable low.
REQ-034 alm_en=1, cur 07:30 -> alm 07:30 -> ed=0 two cycles after match; 5 ticks with no key -> ed=1, state DONE, IDLE after cur_mm=31.
REQ-035 In RING press set -> SNOOZE, ed=1; after 3 ticks -> RING, ed=0; press stop -> DONE.
REQ-036 set_press and stop_press in the same cycle during RING -> DONE; alm_en dropped in the same cycle as stop_press -> IDLE.
REQ-037 rst pulse during RING with match held -> ed=1 immediately, state IDLE, no ring until match toggles.
